irq_collector: RTL and testbench

IRQ_COLLECTOR -- requirements
Module: irq_collector

---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_edge_det.sv | 24 ++
 rtl/irq_collector.sv | 95 +++++++++
 tb/tb_irq_collector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt collector.
package irq_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector: keeps the previous request levels and flags 0->1 transitions.
module irq_edge_det #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] req_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] req_d;

    // Reset to zero so a line already high at reset release counts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= '0;
        end else begin
            req_d <= req_in;
        end
    end

    assign rise = req_in & ~req_d;

endmodule

// File: rtl/irq_collector.sv
// Collects edge-triggered requests into a pending vector and presents one index at a
// time, using an external priority encoder that maps pend_o to idx_i.
module irq_collector
    import irq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [(2**N)-1:0] req_in,
    input  logic [(2**N)-1:0] mask,
    output logic [(2**N)-1:0] pend_o,
    input  logic [N-1:0]      idx_i,
    output logic              irq_valid,
    output logic [N-1:0]      irq_id,
    input  logic              irq_ack,
    output logic [(2**N)-1:0] ovf_o,
    output logic              err_o,
    input  logic              clr_i,
    output irq_state_t        dbg_state
);

    localparam int W = 2**N;

    // Handshake: irq_id is offered while irq_valid is high and is held unchanged
    // until the edge where irq_ack is also high; that edge completes the transfer.

    irq_state_t   state;
    logic [W-1:0] pending;
    logic [W-1:0] rise;
    logic [W-1:0] clear_vec;
    logic [W-1:0] ovf_set;
    logic         any_pend;
    logic         idx_hit;
    logic         err_set;

    irq_edge_det #(.W(W)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .rise   (rise)
    );

    assign pend_o    = pending & mask;
    assign any_pend  = |pend_o;
    assign idx_hit   = pend_o[idx_i];
    assign irq_valid = (state == PRESENT);
    assign dbg_state = state;

    always_comb begin
        clear_vec = '0;
        if (state == PRESENT && irq_ack) begin
            clear_vec[irq_id] = 1'b1;
        end
    end

    // A rise on the bit being acknowledged is a fresh request, not a lost one.
    assign ovf_set = rise & pending & ~clear_vec;
    assign err_set = (state == IDLE) && any_pend && !idx_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            ovf_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            pending <= (pending & ~clear_vec) | rise;
            ovf_o   <= clr_i ? ovf_set : (ovf_o | ovf_set);
            err_o   <= clr_i ? err_set : (err_o | err_set);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend && idx_hit) begin
                        irq_id <= idx_i;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_collector.sv
// Randomized and directed bench for irq_collector with a reference encoder and a
// line-by-line behavioural model; presentations are checked through an expected queue.
module tb_irq_collector;
    import irq_pkg::*;

    localparam int N = 4;
    localparam int W = 2**N;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] req_in;
    logic [W-1:0] mask;
    logic [W-1:0] pend_o;
    logic [N-1:0] idx_i;
    logic         irq_valid;
    logic [N-1:0] irq_id;
    logic         irq_ack;
    logic [W-1:0] ovf_o;
    logic         err_o;
    logic         clr_i;
    irq_state_t   dbg_state;

    logic         force_en;
    logic [N-1:0] force_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] exp_q[$];

    // model state
    logic [W-1:0] m_pend;
    logic [W-1:0] m_reqd;
    logic [W-1:0] m_ovf;
    logic         m_err;
    logic         m_busy;
    logic [N-1:0] m_id;

    irq_collector #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .pend_o    (pend_o),
        .idx_i     (idx_i),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .ovf_o     (ovf_o),
        .err_o     (err_o),
        .clr_i     (clr_i),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] enc(input logic [W-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) r = i[N-1:0];
        end
        return r;
    endfunction

    always_comb begin
        idx_i = force_en ? force_idx : enc(pend_o);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_reqd = '0;
        m_ovf  = '0;
        m_err  = 1'b0;
        m_busy = 1'b0;
        m_id   = '0;
        exp_q.delete();
    endtask

    // Predict the effect of the next rising edge given the inputs now applied.
    task automatic model_edge();
        logic [W-1:0] visible;
        logic [W-1:0] new_ovf;
        logic [N-1:0] sel;
        logic         err_hit;
        int           cleared;
        visible = m_pend & mask;
        new_ovf = '0;
        err_hit = 1'b0;
        cleared = (m_busy && irq_ack) ? int'(m_id) : -1;
        if (!m_busy) begin
            if (visible != '0) begin
                sel = force_en ? force_idx : enc(visible);
                if (visible[sel]) begin
                    m_busy = 1'b1;
                    m_id   = sel;
                    exp_q.push_back(sel);
                end else begin
                    err_hit = 1'b1;
                end
            end
        end else if (irq_ack) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
            if (req_in[i] && !m_reqd[i]) begin
                if (m_pend[i] && i != cleared) new_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
            end else if (i == cleared) begin
                m_pend[i] = 1'b0;
            end
        end
        m_reqd = req_in;
        m_ovf  = clr_i ? new_ovf : (m_ovf | new_ovf);
        m_err  = clr_i ? err_hit : (m_err | err_hit);
    endtask

    task automatic check_regs();
        chk("pend_o", pend_o, m_pend & mask);
        chk("ovf_o", ovf_o, m_ovf);
        chk("err_o", err_o, m_err);
        chk("irq_valid", irq_valid, m_busy);
        chk("dbg_state", dbg_state, m_busy);
        if (m_busy) chk("irq_id", irq_id, m_id);
    endtask

    // driver: called right after a falling edge
    task automatic sv(input logic [W-1:0] r, input logic [W-1:0] m, input logic a, input logic c);
        req_in  = r;
        mask    = m;
        irq_ack = a;
        clr_i   = c;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset(input logic [W-1:0] r);
        rst_n    = 1'b0;
        req_in   = r;
        mask     = '1;
        irq_ack  = 1'b0;
        clr_i    = 1'b0;
        force_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_regs();
    endtask

    // monitor: every new presentation must match the head of the expected queue
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (irq_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL present_id: got %0d with no presentation expected at %0t", irq_id, $time);
            end else begin
                chk("present_id", irq_id, exp_q.pop_front());
            end
        end
        prev_valid = irq_valid;
    end

    localparam logic [W-1:0] ALL = '1;

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] m;
        logic [W-1:0] one;
        logic         a;
        one       = 1;
        force_idx = '0;
        do_reset('0);

        // single request on line 5
        sv(one << 5, ALL, 0, 0);
        chk("t5_pend", pend_o, 32'h0020);
        chk("t5_valid_E0", irq_valid, 0);
        sv(one << 5, ALL, 0, 0);
        chk("t5_valid", irq_valid, 1);
        chk("t5_id", irq_id, 5);
        sv(one << 5, ALL, 1, 0);
        chk("t5_ack_valid", irq_valid, 0);
        chk("t5_ack_pend", pend_o, 0);
        sv('0, ALL, 0, 0);

        // lines 3 and 12 together: 12 first, then 3 after one idle cycle
        sv((one << 3) | (one << 12), ALL, 0, 0);
        sv('0, ALL, 0, 0);
        chk("t12_id", irq_id, 12);
        sv('0, ALL, 1, 0);
        chk("t12_gap", irq_valid, 0);
        sv('0, ALL, 0, 0);
        chk("t3_id", irq_id, 3);
        sv('0, ALL, 1, 0);

        // masked line 7 stays silent until unmasked
        sv(one << 7, ~(one << 7), 0, 0);
        for (int i = 0; i < 10; i++) sv(one << 7, ~(one << 7), 0, 0);
        sv(one << 7, ALL, 0, 0);
        chk("t7_id", irq_id, 7);
        sv('0, ALL, 1, 0);

        // line 9 pulses twice before ack
        sv(one << 9, ALL, 0, 0);
        sv('0, ALL, 0, 0);
        sv(one << 9, ALL, 0, 0);
        chk("t9_ovf", ovf_o, 32'h0200);
        sv('0, ALL, 1, 0);
        sv('0, ALL, 0, 0);
        sv('0, ALL, 0, 0);
        chk("t9_single", irq_valid, 0);
        sv('0, ALL, 0, 1);
        chk("t9_clr", ovf_o, 0);

        // rise on line 4 coincident with its ack
        sv(one << 4, ALL, 0, 0);
        sv('0, ALL, 0, 0);
        sv(one << 4, ALL, 1, 0);
        chk("t4_noovf", ovf_o, 0);
        sv('0, ALL, 0, 0);
        chk("t4_again", irq_id, 4);
        sv('0, ALL, 1, 0);

        // encoder disagreement
        force_en  = 1'b1;
        force_idx = 4'd2;
        sv(one << 4, ALL, 0, 0);
        sv(one << 4, ALL, 0, 0);
        chk("terr_err", err_o, 1);
        chk("terr_valid", irq_valid, 0);
        force_en = 1'b0;
        sv('0, ALL, 0, 0);
        sv('0, ALL, 1, 1);
        chk("terr_clr", err_o, 0);

        // asynchronous reset while presenting
        sv(one << 1, ALL, 0, 0);
        sv(one << 1, ALL, 0, 0);
        chk("tar_valid_pre", irq_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("tar_valid", irq_valid, 0);
        chk("tar_pend", pend_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // line high across reset release registers as a rise
        do_reset(one << 6);
        sv(one << 6, ALL, 0, 0);
        chk("trst_rise", pend_o, 32'h0040);

        // randomized traffic
        r = one << 6;
        m = ALL;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) r = r ^ (one << $urandom_range(0, W - 1));
            if ($urandom_range(0, 15) == 0) m = $urandom_range(0, 65535);
            else if ($urandom_range(0, 7) == 0) m = ALL;
            a = irq_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            sv(r, m, a, $urandom_range(0, 19) == 0);
        end

        // drain
        for (int k = 0; k < 40; k++) sv('0, ALL, irq_valid, 0);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
